wb_commit: RTL and testbench
============================

WB_COMMIT -- requirements
Module: wb_commit

Parameters
REQ-001 SHALL provide parameters, one per line:
- WIDTH, 16, width of the pc_inc, alu_out, mem_out and wr_data datapaths.
- CNT_W, 16, width of the retire counter.

Interface
REQ-002 SHALL provide these ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered for writeback.
- in_ready  out  1  stage accepts the offer this cycle.
- instr  in  16  instruction word (opcode in [15:11], func in [1:0]).
- pc_inc  in  WIDTH  PC+2 of the instruction.
- alu_out  in  WIDTH  ALU result.
- mem_out  in  WIDTH  load data, valid when mem_done=1.
- mem_done  in  1  load data available this cycle.
- wr_en  out  1  register-file write strobe.
- wr_reg  out  3  destination register.
- wr_data  out  WIDTH  write data.
- retire_cnt  out  CNT_W  count of register writes performed.

Function
REQ-003 SHALL accept an instruction only on a cycle where in_valid=1 and in_ready=1.
REQ-004 SHALL select the source and destination for each accepted instruction as follows:
- R-format ops (11011 all funcs; SEQ 11100, SLT 11101, SLE 11110, SCO 11111, BTR 11001): alu_out, Rd=instr[4:2].
- I-format ops (ADDI 01000, SUBI 01001, ORI 01010, ANDI 01011, ROLI 10100, SLLI 10101, RORI 10110, SRAI 10111): alu_out, Rd=instr[7:5].
- LD 10001: mem_out, Rd=instr[7:5].
- LBI 11000, SLBI 10010, STU 10011: alu_out, Rd=instr[10:8].
- JAL 00110, JALR 00111: pc_inc, Rd=7.
REQ-005 SHALL treat every other opcode as non-writing: the instruction is accepted, produces no wr_en and leaves retire_cnt unchanged.
REQ-006 SHALL implement two states, PASS and WAIT_MEM; in_ready is 1 in PASS and 0 in WAIT_MEM.
REQ-007 In PASS, a writing instruction that is not LD, or an LD with mem_done=1, SHALL register wr_reg and wr_data and assert wr_en for exactly the next cycle (latency 1).
REQ-008 In PASS, an LD accepted with mem_done=0 SHALL capture Rd and transition to WAIT_MEM.
REQ-009 In WAIT_MEM, on the first cycle with mem_done=1 the block SHALL capture mem_out, assert wr_en with the captured Rd on the next cycle, and return to PASS.
REQ-010 In WAIT_MEM, in_valid and instr SHALL be ignored.
REQ-011 The stage SHALL accept back-to-back instructions in PASS, giving one wr_en per cycle with no bubble.
REQ-012 wr_en SHALL be 0 on every cycle that does not follow a completing write under REQ-007 or REQ-009.
REQ-013 When wr_en=0, wr_reg and wr_data SHALL hold their last values.
REQ-014 retire_cnt SHALL increment by 1 on each cycle wr_en=1.
REQ-015 retire_cnt SHALL wrap modulo 2^CNT_W without saturation.
REQ-016 Data SHALL pass unmodified at WIDTH bits; no sign or zero extension is performed in this block.

Reset
REQ-017 While rst=1, regardless of clk: state=PASS, wr_en=0, wr_reg=0, wr_data=0, retire_cnt=0.
REQ-018 Reset asserted in WAIT_MEM SHALL discard the pending load; no write occurs after reset releases.
REQ-019 On the first clock after rst deasserts, the stage SHALL accept input (in_ready=1).

Verification
REQ-020 The bench SHALL cover these scenarios:
- ADD instr=0xD94C, alu_out=0x1234, in_valid=1 -> next cycle wr_en=1, wr_reg=3, wr_data=0x1234, retire_cnt=1.
- ADDI 0x4145 then JAL 0x3000 with pc_inc=0x0042 on consecutive cycles -> wr_reg=2 with alu_out, then wr_reg=7 with wr_data=0x0042, no bubble.
- LD 0x8941 with mem_done=0 for 3 cycles, then mem_out=0xBEEF with mem_done=1 -> in_ready=0 for 3 cycles, then one wr_en with wr_reg=2, wr_data=0xBEEF.
- ST 0x8000 accepted -> wr_en stays 0, retire_cnt unchanged.
- CNT_W=4, 17 writes -> retire_cnt=1.
- rst pulsed during WAIT_MEM, then mem_done=1 -> no wr_en, all outputs 0, in_ready=1.

Source files
------------

// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit
// Purpose  : Writeback/commit stage. Decodes the destination register and
//            data source of each accepted instruction, issues one registered
//            register-file write strobe per writing instruction, stalls on
//            loads whose data is not yet available, and counts retired writes.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    input  logic [WIDTH-1:0] pc_inc,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] mem_out,
    input  logic             mem_done,
    output logic             wr_en,
    output logic [2:0]       wr_reg,
    output logic [WIDTH-1:0] wr_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [0:0] S_PASS     = 1'b0;
    localparam logic [0:0] S_WAIT_MEM = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [4:0]       w_opcode;
    logic             w_accept;
    logic             w_writes;
    logic             w_is_ld;
    logic [2:0]       w_rd;
    logic [WIDTH-1:0] w_src_data;
    logic             w_do_write;
    logic [2:0]       w_wr_reg_next;
    logic [WIDTH-1:0] w_wr_data_next;
    logic             w_capture_rd;
    logic [2:0]       r_pend_rd;
    logic             r_wr_en;
    logic [2:0]       r_wr_reg;
    logic [WIDTH-1:0] r_wr_data;
    logic [CNT_W-1:0] r_retire_cnt;

    // The func field never changes the writeback decision in this stage.
    logic w_unused_func;
    assign w_unused_func = &{1'b0, instr[1:0]};

    assign w_opcode   = instr[15:11];
    assign in_ready   = (r_state == S_PASS);
    assign w_accept   = in_valid && in_ready;
    assign wr_en      = r_wr_en;
    assign wr_reg     = r_wr_reg;
    assign wr_data    = r_wr_data;
    assign retire_cnt = r_retire_cnt;

    // Decode: does this opcode write, which field names Rd, and where data comes from
    always_comb begin
        w_writes   = 1'b0;
        w_is_ld    = 1'b0;
        w_rd       = 3'd0;
        w_src_data = alu_out;
        case (w_opcode)
            5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111, 5'b11001: begin
                w_writes = 1'b1;
                w_rd     = instr[4:2];
            end
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                w_writes = 1'b1;
                w_rd     = instr[7:5];
            end
            5'b10001: begin
                w_writes   = 1'b1;
                w_is_ld    = 1'b1;
                w_rd       = instr[7:5];
                w_src_data = mem_out;
            end
            5'b11000, 5'b10010, 5'b10011: begin
                w_writes = 1'b1;
                w_rd     = instr[10:8];
            end
            5'b00110, 5'b00111: begin
                w_writes   = 1'b1;
                w_rd       = 3'd7;
                w_src_data = pc_inc;
            end
            default: begin
                w_writes = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_PASS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a load without data parks the stage until mem_done
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PASS: begin
                if (w_accept && w_writes && w_is_ld && !mem_done) begin
                    w_state_next = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                if (mem_done) begin
                    w_state_next = S_PASS;
                end
            end
            default: begin
                w_state_next = S_PASS;
            end
        endcase
    end

    // Output decode: what gets written on the next cycle, and when to hold Rd
    always_comb begin
        w_do_write     = 1'b0;
        w_wr_reg_next  = w_rd;
        w_wr_data_next = w_src_data;
        w_capture_rd   = 1'b0;
        case (r_state)
            S_PASS: begin
                if (w_accept && w_writes) begin
                    if (!w_is_ld || mem_done) begin
                        w_do_write = 1'b1;
                    end else begin
                        w_capture_rd = 1'b1;
                    end
                end
            end
            S_WAIT_MEM: begin
                w_wr_reg_next  = r_pend_rd;
                w_wr_data_next = mem_out;
                w_do_write     = mem_done;
            end
            default: begin
                w_do_write = 1'b0;
            end
        endcase
    end

    // Write port and retire counter; wr_reg/wr_data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en      <= 1'b0;
            r_wr_reg     <= 3'd0;
            r_wr_data    <= '0;
            r_retire_cnt <= '0;
            r_pend_rd    <= 3'd0;
        end else begin
            r_wr_en <= w_do_write;
            if (w_do_write) begin
                r_wr_reg     <= w_wr_reg_next;
                r_wr_data    <= w_wr_data_next;
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
            if (w_capture_rd) begin
                r_pend_rd <= w_rd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit
// Purpose  : Directed vector table plus hand-written load-stall, reset and
//            counter-wrap sequences for wb_commit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] mem;
        logic        mem_done;
        logic        in_valid;
        logic        exp_en;
        logic [2:0]  exp_reg;
        logic [15:0] exp_data;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic [15:0] alu_out;
    logic [15:0] mem_out;
    logic        mem_done;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;
    logic [15:0] retire_cnt;

    logic        in_ready4;
    logic        wr_en4;
    logic [2:0]  wr_reg4;
    logic [15:0] wr_data4;
    logic [3:0]  retire_cnt4;

    int pass_cnt;
    int total_cnt;

    wb_commit #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_inc(pc_inc), .alu_out(alu_out), .mem_out(mem_out),
        .mem_done(mem_done), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .retire_cnt(retire_cnt)
    );

    wb_commit #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .instr(instr), .pc_inc(pc_inc), .alu_out(alu_out), .mem_out(mem_out),
        .mem_done(mem_done), .wr_en(wr_en4), .wr_reg(wr_reg4), .wr_data(wr_data4),
        .retire_cnt(retire_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] alu,
                         input logic [15:0] pc, input logic [15:0] mem, input logic md);
        in_valid = v;
        instr    = ins;
        alu_out  = alu;
        pc_inc   = pc;
        mem_out  = mem;
        mem_done = md;
    endtask

    function automatic vec_t mk(input logic [15:0] ins, input logic [15:0] alu,
                                input logic [15:0] pc, input logic [15:0] mem,
                                input logic md, input logic v, input logic en,
                                input logic [2:0] rg, input logic [15:0] dat);
        vec_t t;
        t.instr = ins; t.alu = alu; t.pc = pc; t.mem = mem; t.mem_done = md;
        t.in_valid = v; t.exp_en = en; t.exp_reg = rg; t.exp_data = dat;
        return t;
    endfunction

    task automatic do_reset();
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    vec_t vecs[14];

    initial begin
        logic [2:0]  m_reg;
        logic [15:0] m_data;
        logic [15:0] m_cnt;

        pass_cnt  = 0;
        total_cnt = 0;

        //            instr     alu       pc        mem       md    v     en    reg   data
        vecs[0]  = mk(16'hD94C, 16'h1234, 16'h0BAD, 16'hDEAD, 1'b0, 1'b1, 1'b1, 3'd3, 16'h1234); // ADD
        vecs[1]  = mk(16'h4145, 16'h5555, 16'h0BAD, 16'hDEAD, 1'b0, 1'b1, 1'b1, 3'd2, 16'h5555); // ADDI
        vecs[2]  = mk(16'h3000, 16'h1111, 16'h0042, 16'hDEAD, 1'b0, 1'b1, 1'b1, 3'd7, 16'h0042); // JAL
        vecs[3]  = mk(16'h8000, 16'h2222, 16'h0BAD, 16'hDEAD, 1'b1, 1'b1, 1'b0, 3'd7, 16'h0042); // ST
        vecs[4]  = mk(16'hD94C, 16'h3333, 16'h0BAD, 16'hDEAD, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0042); // idle
        vecs[5]  = mk(16'h8941, 16'h4444, 16'h0BAD, 16'hCAFE, 1'b1, 1'b1, 1'b1, 3'd2, 16'hCAFE); // LD hit
        vecs[6]  = mk(16'hC512, 16'h00FF, 16'h0BAD, 16'hDEAD, 1'b0, 1'b1, 1'b1, 3'd5, 16'h00FF); // LBI
        vecs[7]  = mk(16'h96AB, 16'h7777, 16'h0BAD, 16'hDEAD, 1'b0, 1'b1, 1'b1, 3'd6, 16'h7777); // SLBI
        vecs[8]  = mk(16'hC81C, 16'h0101, 16'h0BAD, 16'hDEAD, 1'b0, 1'b1, 1'b1, 3'd7, 16'h0101); // BTR
        vecs[9]  = mk(16'h3800, 16'h0202, 16'hFFFE, 16'hDEAD, 1'b0, 1'b1, 1'b1, 3'd7, 16'hFFFE); // JALR
        vecs[10] = mk(16'h5060, 16'h8000, 16'h0BAD, 16'hDEAD, 1'b1, 1'b1, 1'b1, 3'd3, 16'h8000); // ORI
        vecs[11] = mk(16'h0800, 16'h9999, 16'h0BAD, 16'hDEAD, 1'b0, 1'b1, 1'b0, 3'd3, 16'h8000); // NOP
        vecs[12] = mk(16'hB8E0, 16'hA5A5, 16'h0BAD, 16'hDEAD, 1'b0, 1'b1, 1'b1, 3'd7, 16'hA5A5); // SRAI
        vecs[13] = mk(16'h8941, 16'h1357, 16'h0BAD, 16'h2468, 1'b1, 1'b0, 1'b0, 3'd7, 16'hA5A5); // LD not offered

        // Reset values, observed while rst is still high
        rst = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        #12;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_reg", {29'd0, wr_reg}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_retire_cnt", {16'd0, retire_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back vector table; bench tracks held outputs and the count
        m_reg  = 3'd0;
        m_data = 16'h0000;
        m_cnt  = 16'd0;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].in_valid, vecs[i].instr, vecs[i].alu, vecs[i].pc,
                  vecs[i].mem, vecs[i].mem_done);
            tick();
            if (vecs[i].exp_en) begin
                m_cnt++;
            end
            m_reg  = vecs[i].exp_reg;
            m_data = vecs[i].exp_data;
            check($sformatf("vec%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vecs[i].exp_en});
            check($sformatf("vec%0d_wr_reg", i), {29'd0, wr_reg}, {29'd0, m_reg});
            check($sformatf("vec%0d_wr_data", i), {16'd0, wr_data}, {16'd0, m_data});
            check($sformatf("vec%0d_retire_cnt", i), {16'd0, retire_cnt}, {16'd0, m_cnt});
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
        end

        // LD stall: three cycles without data, ADD offered meanwhile is ignored
        drive(1'b1, 16'h8941, 16'h1111, 16'h0BAD, 16'h0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("ld_wait%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("ld_wait%0d_wr_en", k), {31'd0, wr_en}, 32'd0);
            drive(1'b1, 16'hD94C, 16'h6666, 16'h0BAD, 16'h0000, 1'b0);
        end
        drive(1'b1, 16'hD94C, 16'h6666, 16'h0BAD, 16'hBEEF, 1'b1);
        tick();
        m_cnt++;
        check("ld_done_wr_en", {31'd0, wr_en}, 32'd1);
        check("ld_done_wr_reg", {29'd0, wr_reg}, 32'd2);
        check("ld_done_wr_data", {16'd0, wr_data}, 32'h0000BEEF);
        check("ld_done_retire_cnt", {16'd0, retire_cnt}, {16'd0, m_cnt});
        check("ld_done_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 16'hD94C, 16'h6666, 16'h0BAD, 16'h0000, 1'b0);
        tick();
        check("ld_after_wr_en", {31'd0, wr_en}, 32'd0);
        check("ld_after_hold_data", {16'd0, wr_data}, 32'h0000BEEF);
        check("ld_after_hold_reg", {29'd0, wr_reg}, 32'd2);

        // Reset pulsed while a load is pending discards it
        drive(1'b1, 16'h8941, 16'h0000, 16'h0BAD, 16'h0000, 1'b0);
        tick();
        check("pend_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0BAD, 16'h0000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("async_rst_wr_data", {16'd0, wr_data}, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0BAD, 16'h5A5A, 1'b1);
        tick();
        check("disc_wr_en", {31'd0, wr_en}, 32'd0);
        check("disc_wr_reg", {29'd0, wr_reg}, 32'd0);
        check("disc_wr_data", {16'd0, wr_data}, 32'd0);
        check("disc_retire_cnt", {16'd0, retire_cnt}, 32'd0);
        check("disc_in_ready", {31'd0, in_ready}, 32'd1);

        // Counter wrap: 17 writes into a 4-bit counter leave it at 1
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 16'hD94C, 16'(k), 16'h0BAD, 16'hDEAD, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0000, 16'h0000, 16'h0BAD, 16'hDEAD, 1'b0);
        check("wrap_cnt4", {28'd0, retire_cnt4}, 32'd1);
        check("wrap_cnt16", {16'd0, retire_cnt}, 32'd17);
        check("wrap_last_data", {16'd0, wr_data}, 32'd16);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
